hps_cmd_decoder: RTL and testbench
==================================

Name: hps_cmd_decoder

Overview:
Receives commands that the HPS writes over the lw-bridge into a 32-bit output PIO, and turns them into hardware-side actions. It injects test pixels into the hog core input through a valid-ready stream, pulses a soft reset, and sets a per-level mask on the hog output ready lines. It reports acceptance and status back through a 32-bit input PIO using a toggle handshake, which makes it the write-direction counterpart of the status PIO block.

Parameters:
- LEVELS, 7, number of hog output levels; sets the width of out_ready_mask.
- FIFO_DEPTH, 16, pixel FIFO entries; must be a power of 2, ≥2.
- RST_CYCLES, 16, soft_rst assertion length in clk cycles; ≥1.

Ports:
- clk  in  1  system clock; the PIO is in the same domain.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_pio  in  32  command word from the HPS output PIO.
- ack_pio  out  32  status word to the HPS input PIO.
- pixel_data  out  8  injected pixel to the hog input.
- pixel_valid  out  1  pixel_data is valid.
- pixel_ready  in  1  hog input ready.
- soft_rst  out  1  active-high soft reset to the hog core and bus-switch.
- out_ready_mask  out  LEVELS  ANDed externally with hog_out_ready.

Behaviour:
- Command word fields:
  - [31] toggle.
  - [30:28] opcode.
  - [27:8] arg.
  - [7:0] data.
- The HPS writes the complete word with toggle inverted relative to ack_pio[31], then polls until ack_pio[31] equals its toggle.
- cmd_pio is registered once into cmd_q. A new command is detected when cmd_q[31] != ack_tog.
- Opcodes:
  - 0 NOP.
  - 1 PUSH_PIXEL: write data into the FIFO.
  - 2 SOFT_RESET.
  - 3 SET_MASK: out_ready_mask <= arg[LEVELS-1:0].
  - 4 CLR_STATUS: clear the sticky flags and pixels_sent.
  - 5..7: set sticky bad_op, no other action.
- FSM states are IDLE, EXEC and RST_HOLD.
  - IDLE: on detection, latch opcode/arg/data and go to EXEC. Otherwise stay.
  - EXEC (1 cycle): perform the action. For opcodes other than 2, ack_tog <= latched toggle, then go to IDLE. For opcode 2, load the counter with RST_CYCLES-1 and go to RST_HOLD.
  - RST_HOLD: soft_rst=1. Counter decrements each cycle. At 0: soft_rst falls, ack_tog updates, go to IDLE.
- Latency: cmd_pio changes in cycle 0 → EXEC in cycle 2 → ack_pio[31] and (for a push into an empty FIFO) pixel_valid are visible in cycle 3.
- Soft reset timing: soft_rst is high for exactly RST_CYCLES cycles starting in cycle 3. Ack follows in the cycle after soft_rst falls.
- Toggle changes while in EXEC or RST_HOLD are not lost. They are detected in the next IDLE cycle.
- Soft reset effects:
  - Flush the FIFO.
  - Hold pixel_valid=0.
  - Clear pixels_sent.
  - Set out_ready_mask to all ones.
  - Sticky flags are retained.
- Stream rules:
  - pixel_valid = FIFO not empty, and not in RST_HOLD.
  - A transfer occurs when pixel_valid && pixel_ready.
  - pixel_data is the FIFO head and stays stable while valid && !ready.
  - pixel_valid never drops without a transfer, except on soft reset.
- FIFO boundaries:
  - A push when full with no pop that cycle is dropped and sets sticky overflow.
  - A push and a pop in the same cycle while full are both accepted; no overflow.
  - Pushing into an empty FIFO gives no bypass: valid appears the next cycle.
- pixels_sent is 16 bits, increments on each transfer, and wraps 0xFFFF→0.
- ack_pio fields:
  - [31] ack_tog.
  - [30] busy: state != IDLE, or a command is pending.
  - [29] overflow.
  - [28] bad_op.
  - [27:24] reserved, 0.
  - [23:16] fifo count, zero-extended.
  - [15:0] pixels_sent.
- Reset values (rst_n low):
  - ack_pio = 0.
  - pixel_valid = 0, pixel_data = 0.
  - soft_rst = 0.
  - out_ready_mask = all ones.
  - State = IDLE, FIFO empty.
  - cmd_q = 0.
- Reset in the middle of RST_HOLD ends the hold immediately; soft_rst goes 0.

Decomposition:
- Package hps_cmd_pkg holds:
  - opcode constants OP_NOP..OP_CLR.
  - field bit positions for cmd_pio and ack_pio.
  - FSM state encodings.
- One sub-module, cmd_pixel_fifo:
  - synchronous FIFO of FIFO_DEPTH × 8 bits, show-ahead.
  - ports: push, pop, flush, full, empty, count.

Test Plan:
- Push 0x5A with toggle=1 into an empty FIFO, pixel_ready=1 → ack_pio[31]=1 in cycle 3; pixel_valid for 1 cycle carrying 0x5A; ack_pio[15:0]=1.
- pixel_ready=0, push 17 pixels 0x00..0x10 → count=16, overflow=1 after the 17th; release ready → 0x00..0x0F are transferred in order, with data stable while stalled.
- SOFT_RESET with 3 pixels queued → soft_rst high exactly 16 cycles; FIFO count 0; pixels_sent=0; out_ready_mask=7'h7F; ack arrives in the cycle after soft_rst falls.
- SET_MASK with arg=0x15 → out_ready_mask=7'h15 in cycle 3; opcode 6 → bad_op=1; CLR_STATUS → bit[29]=0, bit[28]=0 and pixels_sent=0.
- Full FIFO with pixel_ready=1 and a simultaneous push → no overflow; count stays at 16.
- Drive rst_n low in the middle of RST_HOLD → soft_rst=0 and ack_pio=0 immediately; out_ready_mask all ones.

Source files
------------

// File: rtl/hps_cmd_decoder_pkg.sv
// Shared constants for the HPS command decoder: opcodes, PIO field positions
// and FSM state encoding.
package hps_cmd_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_RST  = 3'd2;
  localparam logic [2:0] OP_MASK = 3'd3;
  localparam logic [2:0] OP_CLR  = 3'd4;

  localparam int unsigned CMD_TOG     = 31;
  localparam int unsigned CMD_OP_HI   = 30;
  localparam int unsigned CMD_OP_LO   = 28;
  localparam int unsigned CMD_ARG_HI  = 27;
  localparam int unsigned CMD_ARG_LO  = 8;
  localparam int unsigned CMD_DATA_HI = 7;
  localparam int unsigned CMD_DATA_LO = 0;

  localparam int unsigned ACK_TOG     = 31;
  localparam int unsigned ACK_BUSY    = 30;
  localparam int unsigned ACK_OVF     = 29;
  localparam int unsigned ACK_BAD     = 28;
  localparam int unsigned ACK_CNT_HI  = 23;
  localparam int unsigned ACK_CNT_LO  = 16;
  localparam int unsigned ACK_SENT_HI = 15;
  localparam int unsigned ACK_SENT_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_RST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/hps_cmd_decoder_if.sv
// Valid-ready pixel stream from the command decoder into the hog core input.
interface hps_cmd_decoder_if;
  logic [7:0] pixel_data;
  logic       pixel_valid;
  logic       pixel_ready;

  modport master (output pixel_data, output pixel_valid, input  pixel_ready);
  modport slave  (input  pixel_data, input  pixel_valid, output pixel_ready);
endinterface

// File: rtl/hps_cmd_decoder_fifo.sv
// Show-ahead synchronous FIFO for injected pixels; flush empties it in one cycle.
module cmd_pixel_fifo #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/hps_cmd_decoder.sv
// Decodes toggle-handshaked HPS PIO commands into pixel injection, soft reset
// and output-ready masking, reporting status back on ack_pio.
module hps_cmd_decoder
  import hps_cmd_pkg::*;
#(
  parameter int unsigned LEVELS     = 7,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         cmd_pio,
  output logic [31:0]         ack_pio,
  hps_cmd_decoder_if.master   pix,
  output logic                soft_rst,
  output logic [LEVELS-1:0]   out_ready_mask
);

  localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CNTW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [31:0]       cmd_q;
  logic [2:0]        op_q, op_d;
  logic [19:0]       arg_q, arg_d;
  logic [7:0]        data_q, data_d;
  logic              tog_q, tog_d;
  logic              ack_tog_q, ack_tog_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [LEVELS-1:0] mask_q, mask_d;
  logic              ovf_q, ovf_d;
  logic              bad_q, bad_d;
  logic [15:0]       sent_q, sent_d;

  logic              pending, push, pop, flush;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [7:0]        fifo_head;

  assign pending = (cmd_q[CMD_TOG] != ack_tog_q);
  assign flush   = (state_q == ST_RST_HOLD);
  assign pop     = pix.pixel_valid && pix.pixel_ready;

  assign pix.pixel_valid = !fifo_empty && (state_q != ST_RST_HOLD);
  assign pix.pixel_data  = pix.pixel_valid ? fifo_head : '0;
  assign soft_rst        = (state_q == ST_RST_HOLD);
  assign out_ready_mask  = mask_q;

  cmd_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (data_q),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    arg_d     = arg_q;
    data_d    = data_q;
    tog_d     = tog_q;
    ack_tog_d = ack_tog_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    ovf_d     = ovf_q;
    bad_d     = bad_q;
    sent_d    = pop ? sent_q + 16'd1 : sent_q;
    push      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pending) begin
          op_d    = cmd_q[CMD_OP_HI:CMD_OP_LO];
          arg_d   = cmd_q[CMD_ARG_HI:CMD_ARG_LO];
          data_d  = cmd_q[CMD_DATA_HI:CMD_DATA_LO];
          tog_d   = cmd_q[CMD_TOG];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_NOP:  ;
          OP_PUSH: push = 1'b1;
          OP_RST:  cnt_d = CNTW'(RST_CYCLES - 1);
          OP_MASK: mask_d = arg_q[LEVELS-1:0];
          OP_CLR: begin
            ovf_d  = 1'b0;
            bad_d  = 1'b0;
            sent_d = '0;
          end
          default: bad_d = 1'b1;
        endcase
        if (op_q == OP_RST) begin
          state_d = ST_RST_HOLD;
        end else begin
          ack_tog_d = tog_q;
          state_d   = ST_IDLE;
        end
      end
      ST_RST_HOLD: begin
        mask_d = '1;
        sent_d = '0;
        if (cnt_q == '0) begin
          ack_tog_d = tog_q;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Overflow only when the push is really dropped (no same-cycle pop).
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      op_q      <= '0;
      arg_q     <= '0;
      data_q    <= '0;
      tog_q     <= 1'b0;
      ack_tog_q <= 1'b0;
      cnt_q     <= '0;
      mask_q    <= '1;
      ovf_q     <= 1'b0;
      bad_q     <= 1'b0;
      sent_q    <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_pio;
      op_q      <= op_d;
      arg_q     <= arg_d;
      data_q    <= data_d;
      tog_q     <= tog_d;
      ack_tog_q <= ack_tog_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      ovf_q     <= ovf_d;
      bad_q     <= bad_d;
      sent_q    <= sent_d;
    end
  end

  always_comb begin
    ack_pio                          = '0;
    ack_pio[ACK_TOG]                 = ack_tog_q;
    ack_pio[ACK_BUSY]                = (state_q != ST_IDLE) || pending;
    ack_pio[ACK_OVF]                 = ovf_q;
    ack_pio[ACK_BAD]                 = bad_q;
    ack_pio[ACK_CNT_HI:ACK_CNT_LO]   = 8'(fifo_count);
    ack_pio[ACK_SENT_HI:ACK_SENT_LO] = sent_q;
  end

endmodule

// File: tb/tb_hps_cmd_decoder.sv
// Directed bench for hps_cmd_decoder: command table plus hand-written
// multi-cycle sequences for overflow, full push/pop, soft reset and reset-in-hold.
module tb_hps_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cmd_pio;
  logic [31:0] ack_pio;
  logic        soft_rst;
  logic [6:0]  out_ready_mask;
  logic        tog;
  int          checks = 0;
  int          errors = 0;

  hps_cmd_decoder_if pix_if ();

  hps_cmd_decoder #(.LEVELS(7), .FIFO_DEPTH(16), .RST_CYCLES(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_pio        (cmd_pio),
    .ack_pio        (ack_pio),
    .pix            (pix_if),
    .soft_rst       (soft_rst),
    .out_ready_mask (out_ready_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cmd;
    logic [31:0] ack;
    logic [6:0]  mask;
    logic        valid;
    logic [7:0]  data;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue a command and wait (bounded) until ack_pio[31] reflects it.
  task automatic do_cmd(input logic [2:0] op, input logic [19:0] arg, input logic [7:0] data);
    logic ok;
    tog = ~tog;
    @(posedge clk);
    #1 cmd_pio = {tog, op, arg, data};
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ack_pio[31] == tog) begin
        ok = 1'b1;
        break;
      end
    end
    check("ack_wait", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  n_hi;
    logic hold_bad;

    vecs[0] = '{cmd: 32'h3000_1500, ack: 32'h0000_0001, mask: 7'h15, valid: 1'b0, data: 8'h00};
    vecs[1] = '{cmd: 32'hE000_0000, ack: 32'h9000_0001, mask: 7'h15, valid: 1'b0, data: 8'h00};
    vecs[2] = '{cmd: 32'h0000_0000, ack: 32'h1000_0001, mask: 7'h15, valid: 1'b0, data: 8'h00};
    vecs[3] = '{cmd: 32'h9000_00C3, ack: 32'h9001_0001, mask: 7'h15, valid: 1'b1, data: 8'hC3};
    vecs[4] = '{cmd: 32'h4000_0000, ack: 32'h0000_0000, mask: 7'h15, valid: 1'b0, data: 8'h00};
    vecs[5] = '{cmd: 32'hB000_7F00, ack: 32'h8000_0000, mask: 7'h7F, valid: 1'b0, data: 8'h00};

    rst_n = 1'b0;
    cmd_pio = '0;
    tog = 1'b0;
    pix_if.pixel_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ack", ack_pio, 32'h0);
    check("rst_valid", {31'd0, pix_if.pixel_valid}, 32'd0);
    check("rst_data", {24'd0, pix_if.pixel_data}, 32'd0);
    check("rst_soft", {31'd0, soft_rst}, 32'd0);
    check("rst_mask", {25'd0, out_ready_mask}, 32'h7F);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency: push 0x5A, ack and valid visible in cycle 3.
    tog = 1'b1;
    @(posedge clk);
    #1 cmd_pio = 32'h9000_005A;
    repeat (3) @(negedge clk);
    check("lat_c2_tog", {31'd0, ack_pio[31]}, 32'd0);
    check("lat_c2_valid", {31'd0, pix_if.pixel_valid}, 32'd0);
    @(negedge clk);
    check("lat_c3_tog", {31'd0, ack_pio[31]}, 32'd1);
    check("lat_c3_valid", {31'd0, pix_if.pixel_valid}, 32'd1);
    check("lat_c3_data", {24'd0, pix_if.pixel_data}, 32'h5A);
    @(negedge clk);
    check("lat_c4_valid", {31'd0, pix_if.pixel_valid}, 32'd0);
    check("lat_c4_ack", ack_pio, 32'h8000_0001);

    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 cmd_pio = vecs[i].cmd;
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d_ack", i), ack_pio, vecs[i].ack);
      check($sformatf("vec%0d_mask", i), {25'd0, out_ready_mask}, {25'd0, vecs[i].mask});
      check($sformatf("vec%0d_valid", i), {31'd0, pix_if.pixel_valid}, {31'd0, vecs[i].valid});
      check($sformatf("vec%0d_data", i), {24'd0, pix_if.pixel_data}, {24'd0, vecs[i].data});
      tog = vecs[i].cmd[31];
      repeat (2) @(negedge clk);
    end

    // Overflow: 17 pushes with the sink stalled.
    pix_if.pixel_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      do_cmd(3'd1, 20'd0, 8'(i));
      if (i == 15) begin
        check("ovf_cnt16", {24'd0, ack_pio[23:16]}, 32'd16);
        check("ovf_pre", {31'd0, ack_pio[29]}, 32'd0);
      end
    end
    check("ovf_cnt17", {24'd0, ack_pio[23:16]}, 32'd16);
    check("ovf_set", {31'd0, ack_pio[29]}, 32'd1);
    repeat (3) @(negedge clk);
    check("stall_valid", {31'd0, pix_if.pixel_valid}, 32'd1);
    check("stall_data", {24'd0, pix_if.pixel_data}, 32'h00);
    pix_if.pixel_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d", i), {23'd0, pix_if.pixel_valid, pix_if.pixel_data}, {23'd0, 1'b1, 8'(i)});
      @(negedge clk);
    end
    check("drain_end_valid", {31'd0, pix_if.pixel_valid}, 32'd0);
    check("drain_sent", {16'd0, ack_pio[15:0]}, 32'd16);

    // Full FIFO: push and pop in the same cycle.
    do_cmd(3'd4, 20'd0, 8'd0);
    check("clr_status", {ack_pio[29:28], ack_pio[15:0]}, 32'd0);
    pix_if.pixel_ready = 1'b0;
    for (int i = 0; i < 16; i++) do_cmd(3'd1, 20'd0, 8'(8'h20 + i));
    check("full_cnt", {24'd0, ack_pio[23:16]}, 32'd16);
    tog = ~tog;
    @(posedge clk);
    #1 cmd_pio = {tog, 3'd1, 20'd0, 8'h30};
    repeat (2) @(posedge clk);
    #1 pix_if.pixel_ready = 1'b1;
    @(posedge clk);
    #1 pix_if.pixel_ready = 1'b0;
    @(negedge clk);
    check("pp_tog", {31'd0, ack_pio[31]}, {31'd0, tog});
    check("pp_cnt", {24'd0, ack_pio[23:16]}, 32'd16);
    check("pp_ovf", {31'd0, ack_pio[29]}, 32'd0);
    check("pp_sent", {16'd0, ack_pio[15:0]}, 32'd1);
    check("pp_head", {24'd0, pix_if.pixel_data}, 32'h21);

    // Soft reset with three pixels queued.
    pix_if.pixel_ready = 1'b1;
    repeat (20) @(negedge clk);
    pix_if.pixel_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_cmd(3'd1, 20'd0, 8'(8'hA0 + i));
    do_cmd(3'd3, 20'h2A, 8'd0);
    check("mask_2a", {25'd0, out_ready_mask}, 32'h2A);
    do_cmd(3'd7, 20'd0, 8'd0);
    check("bad_op7", {31'd0, ack_pio[28]}, 32'd1);
    check("sr_pre_cnt", {24'd0, ack_pio[23:16]}, 32'd3);
    tog = ~tog;
    @(posedge clk);
    #1 cmd_pio = {tog, 3'd2, 20'd0, 8'd0};
    repeat (3) @(negedge clk);
    check("sr_c2_low", {31'd0, soft_rst}, 32'd0);
    n_hi = 0;
    hold_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!soft_rst) break;
      n_hi++;
      if (pix_if.pixel_valid || (ack_pio[31] == tog)) hold_bad = 1'b1;
    end
    check("sr_len", n_hi, 32'd16);
    check("sr_hold_quiet", {31'd0, hold_bad}, 32'd0);
    check("sr_ack", ack_pio, {tog, 3'b001, 28'd0});
    check("sr_mask", {25'd0, out_ready_mask}, 32'h7F);
    check("sr_valid", {31'd0, pix_if.pixel_valid}, 32'd0);

    // Hard reset in the middle of the hold.
    tog = ~tog;
    @(posedge clk);
    #1 cmd_pio = {tog, 3'd2, 20'd0, 8'd0};
    repeat (8) @(posedge clk);
    #1 check("mid_hold_high", {31'd0, soft_rst}, 32'd1);
    rst_n = 1'b0;
    cmd_pio = '0;
    #1;
    check("mid_rst_soft", {31'd0, soft_rst}, 32'd0);
    check("mid_rst_ack", ack_pio, 32'h0);
    check("mid_rst_mask", {25'd0, out_ready_mask}, 32'h7F);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tog = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_ack", ack_pio, 32'h0);
    check("post_rst_soft", {31'd0, soft_rst}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
